// File: rtl/mem_bus_arbiter_if.sv
// CPU/DMA/memory-controller signal bundle for mem_bus_arbiter.
// slave = arbiter view; master = requesters plus memory controller view.
interface mem_bus_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_ack;

    logic        dma_req;
    logic        dma_we;
    logic [31:0] dma_addr;
    logic [31:0] dma_wdata;
    logic [31:0] dma_rdata;
    logic        dma_ack;

    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data_out;
    logic        busy;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_data_out,
        output cpu_rdata, cpu_ack, dma_rdata, dma_ack,
        output mem_address, mem_data_in, mem_read, mem_write, busy
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_data_out,
        input  cpu_rdata, cpu_ack, dma_rdata, dma_ack,
        input  mem_address, mem_data_in, mem_read, mem_write, busy
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// CPU/DMA arbiter in front of the single-port memory controller, with per-region wait states.
// Optional macro ARB_WAITSTATE_EN enables the region wait-state table; otherwise W=0 always.
module mem_bus_arbiter #(
    parameter int WS_EWRAM      = 2,
    parameter int WS_ROM        = 4,
    parameter int DMA_BURST_MAX = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    mem_bus_arbiter_if.slave   bus
);

    localparam int SW     = $clog2(DMA_BURST_MAX + 1);
    localparam int WS_MAX = (WS_EWRAM > WS_ROM) ? WS_EWRAM : WS_ROM;
    localparam int WW     = $clog2(WS_MAX + 2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_CAPTURE,
        ST_ACK
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            r_gnt_dma;
    logic            r_we;
    logic [31:2]     r_addr;
    logic [31:0]     r_wdata;
    logic [31:0]     r_cpu_rdata;
    logic [31:0]     r_dma_rdata;
    logic [WW-1:0]   r_wait_cnt;
    logic [WW-1:0]   w_wait_cnt_next;
    logic [SW-1:0]   r_starve;
    logic [SW-1:0]   w_starve_next;
    logic            w_grant;
    logic            w_grant_dma;
    logic [WW-1:0]   w_ws;

`ifdef ARB_WAITSTATE_EN
    always_comb begin
        unique case (r_addr[31:24])
            8'h02:        w_ws = WW'(WS_EWRAM);
            8'h08, 8'h09: w_ws = WW'(WS_ROM);
            default:      w_ws = '0;
        endcase
    end
`else
    assign w_ws = '0;
`endif

    // Next-state, grant decision and counter updates.
    always_comb begin
        w_state_next    = r_state;
        w_grant         = 1'b0;
        w_grant_dma     = 1'b0;
        w_starve_next   = r_starve;
        w_wait_cnt_next = r_wait_cnt;
        case (r_state)
            ST_IDLE: begin
                if (bus.cpu_req || bus.dma_req) begin
                    w_grant      = 1'b1;
                    w_state_next = ST_ISSUE;
                    if (bus.dma_req &&
                        !(bus.cpu_req && r_starve == SW'(DMA_BURST_MAX))) begin
                        w_grant_dma = 1'b1;
                        // a pending CPU implies the counter is below its limit here
                        if (bus.cpu_req)
                            w_starve_next = r_starve + SW'(1);
                    end else begin
                        w_starve_next = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_ws != '0) begin
                    w_state_next    = ST_WAIT;
                    w_wait_cnt_next = w_ws;
                end else begin
                    w_state_next = ST_CAPTURE;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt <= WW'(1)) begin
                    w_state_next    = ST_CAPTURE;
                    w_wait_cnt_next = '0;
                end else begin
                    w_wait_cnt_next = r_wait_cnt - WW'(1);
                end
            end
            ST_CAPTURE: w_state_next = ST_ACK;
            ST_ACK:     w_state_next = ST_IDLE;
            default:    w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_starve   <= '0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_starve   <= w_starve_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Request attributes are frozen at grant; read data only overwrites rdata on reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt_dma   <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            if (w_grant) begin
                r_gnt_dma <= w_grant_dma;
                r_we      <= w_grant_dma ? bus.dma_we    : bus.cpu_we;
                r_addr    <= w_grant_dma ? bus.dma_addr[31:2] : bus.cpu_addr[31:2];
                r_wdata   <= w_grant_dma ? bus.dma_wdata : bus.cpu_wdata;
            end
            if (r_state == ST_CAPTURE && !r_we) begin
                if (r_gnt_dma)
                    r_dma_rdata <= bus.mem_data_out;
                else
                    r_cpu_rdata <= bus.mem_data_out;
            end
        end
    end

    assign bus.mem_read    = (r_state == ST_ISSUE) && !r_we;
    assign bus.mem_write   = (r_state == ST_ISSUE) &&  r_we;
    assign bus.mem_address = {r_addr, 2'b00};
    assign bus.mem_data_in = r_wdata;
    assign bus.cpu_ack     = (r_state == ST_ACK) && !r_gnt_dma;
    assign bus.dma_ack     = (r_state == ST_ACK) &&  r_gnt_dma;
    assign bus.cpu_rdata   = r_cpu_rdata;
    assign bus.dma_rdata   = r_dma_rdata;
    assign bus.busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus random serial traffic
// checked against a region/latency/shadow-memory reference model.
module tb_mem_bus_arbiter;

    localparam int WS_EWRAM = 2;
    localparam int WS_ROM   = 4;
    localparam int BURST    = 16;

`ifdef ARB_WAITSTATE_EN
    localparam int EXP_EW = WS_EWRAM;
    localparam int EXP_ER = WS_ROM;
`else
    localparam int EXP_EW = 0;
    localparam int EXP_ER = 0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_bus_arbiter_if bus ();

    mem_bus_arbiter #(
        .WS_EWRAM      (WS_EWRAM),
        .WS_ROM        (WS_ROM),
        .DMA_BURST_MAX (BURST)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // ---------------- environment: memory controller stand-in ----------------
    logic [31:0] env_mem [int unsigned];

    function automatic bit is_rw(input logic [7:0] r);
        return (r == 8'h02) || (r == 8'h03);
    endfunction

    function automatic bit is_ro(input logic [7:0] r);
        return (r == 8'h00) || (r == 8'h08) || (r == 8'h09);
    endfunction

    function automatic logic [31:0] ro_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'h5A5A_C3C3;
    endfunction

    always @(posedge clk) begin : env
        int unsigned k;
        k = {2'b00, bus.mem_address[31:2]};
        if (bus.mem_read) begin
            if (is_rw(bus.mem_address[31:24]))
                bus.mem_data_out <= env_mem.exists(k) ? env_mem[k] : 32'h0;
            else if (is_ro(bus.mem_address[31:24]))
                bus.mem_data_out <= ro_word(bus.mem_address);
            else
                bus.mem_data_out <= 32'h0;
        end
        if (bus.mem_write && is_rw(bus.mem_address[31:24]))
            env_mem[k] = bus.mem_data_in;
    end

    // ---------------- monitor ----------------
    int          cpu_acks = 0;
    int          dma_acks = 0;
    int          strobes  = 0;
    logic [31:0] strobe_addr = '0;
    logic [31:0] strobe_data = '0;
    logic        strobe_we   = 1'b0;

    always @(negedge clk) begin
        if (bus.cpu_ack) cpu_acks++;
        if (bus.dma_ack) dma_acks++;
        if (bus.mem_read || bus.mem_write) begin
            strobes++;
            strobe_addr = bus.mem_address;
            strobe_data = bus.mem_data_in;
            strobe_we   = bus.mem_write;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [int unsigned];

    function automatic int exp_ws(input logic [31:0] a);
        case (a[31:24])
            8'h02:        return EXP_EW;
            8'h08, 8'h09: return EXP_ER;
            default:      return 0;
        endcase
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        int unsigned k;
        k = {2'b00, a[31:2]};
        if (is_rw(a[31:24])) return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
        if (is_ro(a[31:24])) return ro_word(a);
        return 32'h0;
    endfunction

    function automatic void model_write(input logic [31:0] a, input logic [31:0] d);
        if (is_rw(a[31:24])) ref_mem[{2'b00, a[31:2]}] = d;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic access(input bit is_dma, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit drop_early);
        int n;
        bit got;
        int s0, c0, d0;
        logic [31:0] rd_before, rd_now;
        s0 = strobes; c0 = cpu_acks; d0 = dma_acks;
        rd_before = is_dma ? bus.dma_rdata : bus.cpu_rdata;
        if (is_dma) begin
            bus.dma_req = 1'b1; bus.dma_we = we; bus.dma_addr = addr; bus.dma_wdata = wdata;
        end else begin
            bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata;
        end
        n = 0; got = 1'b0;
        while (!got && n < 40) begin
            step();
            n++;
            if (n == 1) begin
                // inputs change after grant; the access in flight must not see them
                if (is_dma) begin
                    bus.dma_addr = $urandom; bus.dma_wdata = $urandom; bus.dma_we = ~we;
                    if (drop_early) bus.dma_req = 1'b0;
                end else begin
                    bus.cpu_addr = $urandom; bus.cpu_wdata = $urandom; bus.cpu_we = ~we;
                    if (drop_early) bus.cpu_req = 1'b0;
                end
            end
            got = is_dma ? bus.dma_ack : bus.cpu_ack;
        end
        chk("ack_seen", 32'(got), 32'd1);
        chk("ack_latency", 32'(n - 1), 32'(2 + exp_ws(addr)));
        rd_now = is_dma ? bus.dma_rdata : bus.cpu_rdata;
        if (we) chk("rdata_hold", rd_now, rd_before);
        else    chk("rdata", rd_now, model_read(addr));
        chk("strobe_cnt", 32'(strobes - s0), 32'd1);
        chk("strobe_addr", strobe_addr, {addr[31:2], 2'b00});
        chk("strobe_we", 32'(strobe_we), 32'(we));
        if (we) chk("strobe_wdata", strobe_data, wdata);
        if (is_dma) bus.dma_req = 1'b0; else bus.cpu_req = 1'b0;
        step();
        step();
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("ack_once", 32'(is_dma ? dma_acks - d0 : cpu_acks - c0), 32'd1);
        chk("ack_other", 32'(is_dma ? cpu_acks - c0 : dma_acks - d0), 32'd0);
        chk("strobe_once", 32'(strobes - s0), 32'd1);
        if (we) model_write(addr, wdata);
        $display("txn %s %s addr=%h wdata=%h rdata=%h lat=%0d drop=%0d",
                 is_dma ? "DMA" : "CPU", we ? "WR" : "RD", addr, wdata, rd_now, n - 1, drop_early);
    endtask

    task automatic contend(input int dma_total, output int dma_before, output int gap);
        int cyc, done, last_dma, cpu_cyc;
        bit cpu_done;
        logic [31:0] dwd;
        dwd = 32'hC0DE_0000 + 32'(dma_total);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0300_0040; bus.cpu_wdata = '0;
        bus.dma_req = 1'b1; bus.dma_we = 1'b1; bus.dma_addr = 32'h0300_0044; bus.dma_wdata = dwd;
        cyc = 0; done = 0; last_dma = 0; cpu_cyc = 0; cpu_done = 1'b0;
        while (!cpu_done && cyc < 400) begin
            step();
            cyc++;
            if (bus.dma_ack) begin
                done++;
                last_dma = cyc;
                model_write(32'h0300_0044, dwd);
                if (done >= dma_total) bus.dma_req = 1'b0;
            end
            if (bus.cpu_ack) begin
                cpu_done = 1'b1;
                cpu_cyc  = cyc;
                chk("contend_rdata", bus.cpu_rdata, model_read(32'h0300_0040));
            end
        end
        bus.cpu_req = 1'b0;
        bus.dma_req = 1'b0;
        chk("contend_cpu_ack", 32'(cpu_done), 32'd1);
        dma_before = done;
        gap = cpu_cyc - last_dma;
        step(); step(); step();
        chk("contend_idle", 32'(bus.busy), 32'd0);
        $display("txn CONTEND dma_grants_before_cpu=%0d cpu_gap=%0d", dma_before, gap);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int dma_before, gap, c0;
        logic [7:0] regions [7];
        regions = '{8'h00, 8'h02, 8'h03, 8'h04, 8'h08, 8'h09, 8'h0E};

        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.dma_req = 0; bus.dma_we = 0; bus.dma_addr = '0; bus.dma_wdata = '0;

        step(); step();
        chk("rst_mem_read",  32'(bus.mem_read),  32'd0);
        chk("rst_mem_write", 32'(bus.mem_write), 32'd0);
        chk("rst_mem_addr",  bus.mem_address,    32'd0);
        chk("rst_mem_din",   bus.mem_data_in,    32'd0);
        chk("rst_cpu_ack",   32'(bus.cpu_ack),   32'd0);
        chk("rst_dma_ack",   32'(bus.dma_ack),   32'd0);
        chk("rst_cpu_rdata", bus.cpu_rdata,      32'd0);
        chk("rst_dma_rdata", bus.dma_rdata,      32'd0);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        rst_n = 1'b1;
        step();

        // reset during ISSUE of a CPU read
        c0 = cpu_acks;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0300_0020;
        step();
        chk("issue_mem_read", 32'(bus.mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mid_busy",     32'(bus.busy),     32'd0);
        bus.cpu_req = 1'b0;
        step(); step(); step();
        chk("rst_mid_no_ack", 32'(cpu_acks - c0), 32'd0);
        rst_n = 1'b1;
        step();

        // write then read back
        access(1'b0, 1'b1, 32'h0300_0010, 32'hDEAD_BEEF, 1'b0);
        access(1'b0, 1'b0, 32'h0300_0010, 32'h0, 1'b0);
        chk("readback_const", bus.cpu_rdata, 32'hDEAD_BEEF);

        // ROM wait states, unmapped read, ROM write ignored
        access(1'b0, 1'b0, 32'h0800_0000, 32'h0, 1'b0);
        access(1'b0, 1'b0, 32'h0400_0000, 32'h0, 1'b0);
        chk("unmapped_zero", bus.cpu_rdata, 32'h0);
        access(1'b0, 1'b1, 32'h0800_0000, 32'h0000_1234, 1'b0);
        access(1'b0, 1'b0, 32'h0800_0000, 32'h0, 1'b0);
        access(1'b1, 1'b0, 32'h0200_0100, 32'h0, 1'b0);

        // request withdrawn the cycle after grant
        access(1'b0, 1'b0, 32'h0300_0010, 32'h0, 1'b1);
        access(1'b1, 1'b1, 32'h0200_0008, 32'h1357_9BDF, 1'b1);

        // simultaneous requests, then a DMA that never lets go
        contend(1, dma_before, gap);
        chk("contend1_dma_first", 32'(dma_before), 32'd1);
        chk("contend1_gap", 32'(gap), 32'd4);
        contend(100, dma_before, gap);
        chk("starve_dma_grants", 32'(dma_before), 32'(BURST));
        chk("starve_gap", 32'(gap), 32'd4);

        // random serial traffic
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = {regions[$urandom_range(0, 6)], 16'h0000, 8'($urandom_range(0, 15) * 4)};
            a[1:0] = 2'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                   ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
